// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: instruction field positions,
// type codes, halt FSM states and the XLEN-independent part of a decoded bundle.
package decode_pkg;

    localparam int OPC_LSB   = 0;
    localparam int OPC_MSB   = 4;
    localparam int RS1_LSB   = 5;
    localparam int RS1_MSB   = 9;
    localparam int RD_LSB    = 10;
    localparam int RD_MSB    = 14;
    localparam int RS2_LSB   = 15;
    localparam int RS2_MSB   = 19;
    localparam int SA_LSB    = 20;
    localparam int SA_MSB    = 24;
    localparam int IMM14_LSB = 15;
    localparam int IMM14_MSB = 28;
    localparam int IMM24_LSB = 5;
    localparam int IMM24_MSB = 28;
    localparam int TYPE_LSB  = 29;
    localparam int TYPE_MSB  = 30;
    localparam int STOP      = 31;

    typedef enum logic [1:0] {
        TYPE_R = 2'b00,
        TYPE_J = 2'b01,
        TYPE_I = 2'b10,
        TYPE_S = 2'b11
    } insn_type_e;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } stage_state_e;

    // Register-side fields of a decoded instruction; the XLEN-wide members
    // (immediate, target, PCs) are added by the stage that knows XLEN.
    typedef struct packed {
        logic       stop;
        insn_type_e itype;
        logic [4:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [4:0] sa;
        logic       use_rs1;
        logic       use_rs2;
        logic       wr_rd;
    } decode_ctrl_t;

endpackage

// File: rtl/decode_stage_insn_field_decode.sv
// Combinational field decoder: splits one instruction word into register
// indices, flags and an XLEN-wide immediate, and forms the J-type target.
module insn_field_decode
    import decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit IMM_I_SIGNED = 1'b1
) (
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] pc,
    output decode_ctrl_t    ctrl,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] imm24_ext;
    logic [XLEN-1:0] imm14_ext;
    logic            imm14_fill;
    insn_type_e      itype;

    assign itype      = insn_type_e'(insn[TYPE_MSB:TYPE_LSB]);
    assign imm14_fill = IMM_I_SIGNED ? insn[IMM14_MSB] : 1'b0;
    assign imm24_ext  = {{(XLEN-24){insn[IMM24_MSB]}}, insn[IMM24_MSB:IMM24_LSB]};
    assign imm14_ext  = {{(XLEN-14){imm14_fill}}, insn[IMM14_MSB:IMM14_LSB]};

    // Select the fields each format owns; everything else stays zero.
    always_comb begin
        ctrl        = '0;
        imm         = '0;
        target      = '0;
        ctrl.stop   = insn[STOP];
        ctrl.itype  = itype;
        ctrl.opcode = insn[OPC_MSB:OPC_LSB];
        case (itype)
            TYPE_R: begin
                ctrl.rs1     = insn[RS1_MSB:RS1_LSB];
                ctrl.rd      = insn[RD_MSB:RD_LSB];
                ctrl.rs2     = insn[RS2_MSB:RS2_LSB];
                ctrl.use_rs1 = 1'b1;
                ctrl.use_rs2 = 1'b1;
                ctrl.wr_rd   = 1'b1;
            end
            TYPE_J: begin
                imm    = imm24_ext;
                target = pc + imm24_ext;
            end
            TYPE_I: begin
                ctrl.rs1     = insn[RS1_MSB:RS1_LSB];
                ctrl.rd      = insn[RD_MSB:RD_LSB];
                ctrl.use_rs1 = 1'b1;
                ctrl.wr_rd   = 1'b1;
                imm          = imm14_ext;
            end
            TYPE_S: begin
                ctrl.rs1     = insn[RS1_MSB:RS1_LSB];
                ctrl.rd      = insn[RD_MSB:RD_LSB];
                ctrl.rs2     = insn[RS2_MSB:RS2_LSB];
                ctrl.sa      = insn[SA_MSB:SA_LSB];
                ctrl.use_rs1 = 1'b1;
                ctrl.use_rs2 = 1'b1;
                ctrl.wr_rd   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: registers decoded bundles into a main + skid buffer,
// halts on a stop instruction until resumed, supports flush and counts deliveries.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit IMM_I_SIGNED = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_pc_next,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_type,
    output logic [4:0]       out_opcode,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_use_rs1,
    output logic             out_use_rs2,
    output logic             out_wr_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_sa,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_pc_next,
    output logic             out_stop,
    input  logic             flush,
    input  logic             resume,
    output logic             halted,
    output logic [CNT_W-1:0] dec_count
);

    if (XLEN < 32) begin : g_xlen_check
        $error("decode_stage: XLEN must be at least 32");
    end

    typedef struct packed {
        decode_ctrl_t    ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
    } decode_bundle_t;

    decode_bundle_t   dec_bundle;
    decode_bundle_t   main_q;
    decode_bundle_t   skid_q;
    logic             main_valid;
    logic             skid_valid;
    stage_state_e     state_q;
    stage_state_e     state_d;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             out_fire;
    logic             stop_fire;

    insn_field_decode #(
        .XLEN         (XLEN),
        .IMM_I_SIGNED (IMM_I_SIGNED)
    ) u_field_decode (
        .insn   (in_insn),
        .pc     (in_pc),
        .ctrl   (dec_bundle.ctrl),
        .imm    (dec_bundle.imm),
        .target (dec_bundle.target)
    );

    assign dec_bundle.pc      = in_pc;
    assign dec_bundle.pc_next = in_pc_next;

    // A full skid entry blocks intake, so at most one bundle ever lands in skid.
    assign in_ready  = rst && (state_q == RUN) && !skid_valid && !flush;
    assign accept    = in_valid && in_ready;
    assign out_fire  = main_valid && out_ready;
    assign stop_fire = out_fire && main_q.ctrl.stop;

    // Main/skid buffer: main refills from skid first, else from the decoder;
    // a stalled main parks the newly accepted bundle in skid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
                skid_q     <= '0;
            end else if (accept) begin
                main_q     <= dec_bundle;
                main_valid <= 1'b1;
            end else begin
                main_q     <= '0;
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec_bundle;
            skid_valid <= 1'b1;
        end
    end

    // Halt FSM next state: a delivered stop bundle wins over a same-cycle flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (accept && in_insn[STOP]) begin
                    state_d = HALT_PEND;
                end
            end
            HALT_PEND: begin
                if (stop_fire) begin
                    state_d = HALTED;
                end else if (flush) begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Halt FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Count bundles handed to execute, including one that leaves during a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (out_fire) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_type    = main_q.ctrl.itype;
    assign out_opcode  = main_q.ctrl.opcode;
    assign out_rs1     = main_q.ctrl.rs1;
    assign out_rs2     = main_q.ctrl.rs2;
    assign out_rd      = main_q.ctrl.rd;
    assign out_use_rs1 = main_q.ctrl.use_rs1;
    assign out_use_rs2 = main_q.ctrl.use_rs2;
    assign out_wr_rd   = main_q.ctrl.wr_rd;
    assign out_imm     = main_q.imm;
    assign out_sa      = main_q.ctrl.sa;
    assign out_target  = main_q.target;
    assign out_pc      = main_q.pc;
    assign out_pc_next = main_q.pc_next;
    assign out_stop    = main_q.ctrl.stop;
    assign halted      = (state_q == HALTED);
    assign dec_count   = count_q;

endmodule
